ram_port_arbiter: RTL and testbench

- Shares the 64x16 single-port program RAM between three requesters: boot loader (bl), CPU core (cpu) and a debug/scan port (dbg).
- While `boot`=1 the boot loader owns the RAM exclusively.
- After boot, cpu and dbg are served round-robin, one access per `ce` cycle; dbg may lock the RAM for bursts.
- Sits between the requesters and the RAM macro and replaces direct boot-loader-to-RAM wiring.

---
 rtl/ram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbiter for the shared 64x16 program RAM: boot loader, CPU and debug port.
// Optional dbg lock watchdog is compiled in with `define RAM_ARB_WDOG_EN.
module ram_port_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 16,
   parameter int LOCK_MAX = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              boot,
   input  logic              bl_req,
   input  logic              bl_rw,
   input  logic [ADDR_W-1:0] bl_adr,
   input  logic [DATA_W-1:0] bl_din,
   output logic              bl_gnt,
   output logic              bl_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              dbg_req,
   input  logic              dbg_rw,
   input  logic [ADDR_W-1:0] dbg_adr,
   input  logic [DATA_W-1:0] dbg_din,
   input  logic              dbg_lock,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic              lock_abort,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_rw,
   output logic              ram_enable,
   output logic [ADDR_W-1:0] ram_adr,
   output logic [DATA_W-1:0] ram_in,
   input  logic [DATA_W-1:0] ram_out,
   output logic [1:0]        o_state
);

   // Handshake: a requester holds req/rw/adr/din until it sees gnt on a ce=1
   // cycle; read data is on rdata while its rvalid is high (sample on ce=1).

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_LAST_CPU = 2'd1,
      ST_LAST_DBG = 2'd2,
      ST_DBG_LOCK = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_bl_gnt;
   logic   w_cpu_gnt;
   logic   w_dbg_gnt;
   logic   w_lock_ok;
   logic   w_wdog_exp;
   logic   r_bl_rvalid;
   logic   r_cpu_rvalid;
   logic   r_dbg_rvalid;

   if (LOCK_MAX < 1) begin : g_bad_lock_max
      $error("LOCK_MAX must be at least 1");
   end

`ifdef RAM_ARB_WDOG_EN
   localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

   logic [CNT_W-1:0] r_wdog_cnt;
   logic             r_lock_blk;
   logic             r_lock_abort;

   assign w_wdog_exp = (r_state == ST_DBG_LOCK) && (r_wdog_cnt == CNT_LAST);
   // After an abort, dbg must drop dbg_lock once before it can lock again.
   assign w_lock_ok  = dbg_lock && !r_lock_blk;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog_cnt   <= '0;
         r_lock_blk   <= 1'b0;
         r_lock_abort <= 1'b0;
      end else begin
         r_lock_abort <= ce && !boot && dbg_lock && w_wdog_exp;
         if (r_state != ST_DBG_LOCK)
            r_wdog_cnt <= '0;
         else if (ce)
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
         if (ce && !boot && dbg_lock && w_wdog_exp)
            r_lock_blk <= 1'b1;
         else if (ce && !dbg_lock)
            r_lock_blk <= 1'b0;
      end
   end

   assign lock_abort = r_lock_abort;
`else
   assign w_wdog_exp = 1'b0;
   assign w_lock_ok  = dbg_lock;
   assign lock_abort = 1'b0;
`endif

   always_comb begin
      w_bl_gnt  = 1'b0;
      w_cpu_gnt = 1'b0;
      w_dbg_gnt = 1'b0;
      if (ce && !rst) begin
         case (r_state)
            ST_BOOT:     w_bl_gnt = bl_req;
            ST_LAST_CPU: begin
               if (dbg_req) w_dbg_gnt = 1'b1;
               else         w_cpu_gnt = cpu_req;
            end
            ST_LAST_DBG: begin
               if (cpu_req) w_cpu_gnt = 1'b1;
               else         w_dbg_gnt = dbg_req;
            end
            ST_DBG_LOCK: w_dbg_gnt = dbg_req;
            default:     ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      if (ce) begin
         if (boot) begin
            w_next = ST_BOOT;
         end else begin
            case (r_state)
               ST_BOOT: w_next = ST_LAST_DBG;
               ST_LAST_CPU, ST_LAST_DBG: begin
                  if (w_cpu_gnt)      w_next = ST_LAST_CPU;
                  else if (w_dbg_gnt) w_next = w_lock_ok ? ST_DBG_LOCK : ST_LAST_DBG;
               end
               ST_DBG_LOCK: begin
                  if (!dbg_lock || w_wdog_exp) w_next = ST_LAST_DBG;
               end
               default: w_next = ST_BOOT;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_BOOT;
         r_bl_rvalid  <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;
      end else if (ce) begin
         r_state      <= w_next;
         r_bl_rvalid  <= w_bl_gnt  && !bl_rw;
         r_cpu_rvalid <= w_cpu_gnt && !cpu_rw;
         r_dbg_rvalid <= w_dbg_gnt && !dbg_rw;
      end
   end

   always_comb begin
      ram_enable = 1'b0;
      ram_rw     = 1'b0;
      ram_adr    = '0;
      ram_in     = '0;
      if (w_bl_gnt) begin
         ram_enable = 1'b1;
         ram_rw     = bl_rw;
         ram_adr    = bl_adr;
         ram_in     = bl_din;
      end else if (w_cpu_gnt) begin
         ram_enable = 1'b1;
         ram_rw     = cpu_rw;
         ram_adr    = cpu_adr;
         ram_in     = cpu_din;
      end else if (w_dbg_gnt) begin
         ram_enable = 1'b1;
         ram_rw     = dbg_rw;
         ram_adr    = dbg_adr;
         ram_in     = dbg_din;
      end
   end

   assign bl_gnt     = w_bl_gnt;
   assign cpu_gnt    = w_cpu_gnt;
   assign dbg_gnt    = w_dbg_gnt;
   assign bl_rvalid  = r_bl_rvalid;
   assign cpu_rvalid = r_cpu_rvalid;
   assign dbg_rvalid = r_dbg_rvalid;
   assign rdata      = ram_out;
   assign o_state    = r_state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed table-driven bench for ram_port_arbiter with a behavioural 64x16 RAM.
// Covers boot ownership, round-robin, ce gating, dbg lock, boot/rst mid-op, watchdog.
module tb_ram_port_arbiter;

   localparam int LM = 16;
   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_LC   = 2'd1;
   localparam logic [1:0] S_LD   = 2'd2;
   localparam logic [1:0] S_LK   = 2'd3;

   logic        clk = 1'b0;
   logic        rst, ce, boot;
   logic        bl_req, bl_rw, cpu_req, cpu_rw, dbg_req, dbg_rw, dbg_lock;
   logic [5:0]  bl_adr, cpu_adr, dbg_adr;
   logic [15:0] bl_din, cpu_din, dbg_din;
   logic        bl_gnt, bl_rvalid, cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic        lock_abort, ram_rw, ram_enable;
   logic [15:0] rdata, ram_in, ram_out;
   logic [5:0]  ram_adr;
   logic [1:0]  o_state;

   logic        ram_clr;
   logic [15:0] mem [64];

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      string       tag;
      logic        rst, ce, boot;
      logic [2:0]  req;
      logic [2:0]  rw;
      logic [5:0]  a;
      logic        lk;
      logic [2:0]  g;
      logic [2:0]  rv;
      logic [1:0]  st;
      logic        ab;
      logic        rchk;
      logic [15:0] rd;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .LOCK_MAX(LM)) dut (
      .clk(clk), .rst(rst), .ce(ce), .boot(boot),
      .bl_req(bl_req), .bl_rw(bl_rw), .bl_adr(bl_adr), .bl_din(bl_din),
      .bl_gnt(bl_gnt), .bl_rvalid(bl_rvalid),
      .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_adr(cpu_adr), .cpu_din(cpu_din),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_adr(dbg_adr), .dbg_din(dbg_din),
      .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .lock_abort(lock_abort), .rdata(rdata),
      .ram_rw(ram_rw), .ram_enable(ram_enable), .ram_adr(ram_adr), .ram_in(ram_in),
      .ram_out(ram_out), .o_state(o_state)
   );

   // RAM macro model: read data appears one clock after the addressed cycle.
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
         ram_out <= 16'h0;
      end else if (ram_enable) begin
         if (ram_rw) mem[ram_adr] <= ram_in;
         else        ram_out <= mem[ram_adr];
      end
   end

   function automatic vec_t V(input string tag, input logic r, input logic c, input logic b,
                              input logic [2:0] req, input logic [2:0] rw, input logic [5:0] a,
                              input logic lk, input logic [2:0] g, input logic [2:0] rv,
                              input logic [1:0] st, input logic rchk, input logic [15:0] rd);
      vec_t v;
      v.tag = tag; v.rst = r; v.ce = c; v.boot = b; v.req = req; v.rw = rw; v.a = a;
      v.lk = lk; v.g = g; v.rv = rv; v.st = st; v.ab = 1'b0; v.rchk = rchk; v.rd = rd;
      return v;
   endfunction

   task automatic chk(input string tag, input string what, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, what, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      logic        e_en, e_rw;
      logic [5:0]  e_adr;
      logic [15:0] e_in;
      @(negedge clk);
      rst = v.rst; ce = v.ce; boot = v.boot; dbg_lock = v.lk;
      bl_req = v.req[2]; cpu_req = v.req[1]; dbg_req = v.req[0];
      bl_rw  = v.rw[2];  cpu_rw  = v.rw[1];  dbg_rw  = v.rw[0];
      bl_adr = v.a; cpu_adr = ~v.a; dbg_adr = v.a;
      bl_din = 16'hA5A5; cpu_din = {10'h300, v.a}; dbg_din = {10'h340, v.a};
      #1;
      n_vec++;
      e_en = 1'b1; e_rw = 1'b0; e_adr = 6'd0; e_in = 16'h0;
      case (v.g)
         3'b100:  begin e_rw = v.rw[2]; e_adr = v.a;  e_in = 16'hA5A5; end
         3'b010:  begin e_rw = v.rw[1]; e_adr = ~v.a; e_in = {10'h300, v.a}; end
         3'b001:  begin e_rw = v.rw[0]; e_adr = v.a;  e_in = {10'h340, v.a}; end
         default: e_en = 1'b0;
      endcase
      chk(v.tag, "gnt", 32'({bl_gnt, cpu_gnt, dbg_gnt}), 32'(v.g));
      chk(v.tag, "rvalid", 32'({bl_rvalid, cpu_rvalid, dbg_rvalid}), 32'(v.rv));
      chk(v.tag, "state", 32'(o_state), 32'(v.st));
      chk(v.tag, "lock_abort", 32'(lock_abort), 32'(v.ab));
      chk(v.tag, "ram_enable", 32'(ram_enable), 32'(e_en));
      chk(v.tag, "ram_rw", 32'(ram_rw), 32'(e_rw));
      chk(v.tag, "ram_adr", 32'(ram_adr), 32'(e_adr));
      chk(v.tag, "ram_in", 32'(ram_in), 32'(e_in));
      if (v.rchk) chk(v.tag, "rdata", 32'(rdata), 32'(v.rd));
   endtask

   initial begin
      vec_t v;
      // clock/reset
      ram_clr = 1'b1; rst = 1'b1; ce = 1'b1; boot = 1'b1; dbg_lock = 1'b0;
      bl_req = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
      bl_rw = 1'b0; cpu_rw = 1'b0; dbg_rw = 1'b0;
      bl_adr = 6'd0; cpu_adr = 6'd0; dbg_adr = 6'd0;
      bl_din = 16'h0; cpu_din = 16'h0; dbg_din = 16'h0;
      repeat (2) @(negedge clk);
      ram_clr = 1'b0;

      tbl.push_back(V("reset",     1,1,1, 3'b111,3'b000,6'd63,0, 3'b000,3'b000,S_BOOT,0,16'h0));
      tbl.push_back(V("t1_bl_wr",  0,1,1, 3'b111,3'b100,6'd63,0, 3'b100,3'b000,S_BOOT,0,16'h0));
      tbl.push_back(V("t1_bl_rd",  0,1,1, 3'b111,3'b000,6'd63,0, 3'b100,3'b000,S_BOOT,0,16'h0));
      tbl.push_back(V("t1_bl_rv",  0,1,1, 3'b011,3'b000,6'd63,0, 3'b000,3'b100,S_BOOT,1,16'hA5A5));
      tbl.push_back(V("t2_boot0",  0,1,0, 3'b011,3'b000,6'd5,0,  3'b000,3'b000,S_BOOT,0,16'h0));
      tbl.push_back(V("t2_cpu1",   0,1,0, 3'b011,3'b000,6'd5,0,  3'b010,3'b000,S_LD,0,16'h0));
      tbl.push_back(V("t2_dbg1",   0,1,0, 3'b011,3'b000,6'd6,0,  3'b001,3'b010,S_LC,1,16'h103A));
      tbl.push_back(V("t2_cpu2",   0,1,0, 3'b011,3'b000,6'd7,0,  3'b010,3'b001,S_LD,1,16'h1006));
      tbl.push_back(V("t2_dbg2",   0,1,0, 3'b011,3'b000,6'd8,0,  3'b001,3'b010,S_LC,1,16'h1038));
      tbl.push_back(V("t2_idle",   0,1,0, 3'b000,3'b000,6'd0,0,  3'b000,3'b001,S_LD,1,16'h1008));
      tbl.push_back(V("t4_ce0a",   0,0,0, 3'b011,3'b000,6'd5,0,  3'b000,3'b000,S_LD,0,16'h0));
      tbl.push_back(V("t4_cpu",    0,1,0, 3'b011,3'b000,6'd5,0,  3'b010,3'b000,S_LD,0,16'h0));
      tbl.push_back(V("t4_ce0b",   0,0,0, 3'b011,3'b000,6'd5,0,  3'b000,3'b010,S_LC,1,16'h103A));
      tbl.push_back(V("t4_dbg",    0,1,0, 3'b011,3'b000,6'd6,0,  3'b001,3'b010,S_LC,1,16'h103A));
      tbl.push_back(V("t4_ce0c",   0,0,0, 3'b011,3'b000,6'd6,0,  3'b000,3'b001,S_LD,1,16'h1006));
      tbl.push_back(V("t4_idle",   0,1,0, 3'b000,3'b000,6'd0,0,  3'b000,3'b001,S_LD,1,16'h1006));
      tbl.push_back(V("wr_cpu",    0,1,0, 3'b010,3'b010,6'd3,0,  3'b010,3'b000,S_LD,0,16'h0));
      tbl.push_back(V("rd_dbg",    0,1,0, 3'b001,3'b000,6'd60,0, 3'b001,3'b000,S_LC,0,16'h0));
      tbl.push_back(V("rd_dbg_rv", 0,1,0, 3'b000,3'b000,6'd0,0,  3'b000,3'b001,S_LD,1,16'hC003));
      tbl.push_back(V("t3_cpu",    0,1,0, 3'b011,3'b000,6'd0,1,  3'b010,3'b000,S_LD,0,16'h0));
      tbl.push_back(V("t3_lock",   0,1,0, 3'b011,3'b000,6'd0,1,  3'b001,3'b010,S_LC,1,16'hA5A5));
      for (int a = 1; a <= 8; a++)
         tbl.push_back(V("t3_locked", 0,1,0, 3'b011,3'b000,6'(a),1, 3'b001,3'b001,S_LK,1,
                         16'h1000 + 16'(a - 1)));
      tbl.push_back(V("t3_unlock", 0,1,0, 3'b011,3'b000,6'd9,0,  3'b001,3'b001,S_LK,1,16'h1008));
      tbl.push_back(V("t3_cpu_nx", 0,1,0, 3'b011,3'b000,6'd10,0, 3'b010,3'b001,S_LD,1,16'h1009));
      tbl.push_back(V("t3_idle",   0,1,0, 3'b000,3'b000,6'd0,0,  3'b000,3'b010,S_LC,1,16'h1035));
      tbl.push_back(V("t5_lockwr", 0,1,0, 3'b001,3'b001,6'd20,1, 3'b001,3'b000,S_LC,0,16'h0));
      tbl.push_back(V("t5_bootlk", 0,1,1, 3'b101,3'b001,6'd21,1, 3'b001,3'b000,S_LK,0,16'h0));
      tbl.push_back(V("t5_blrd",   0,1,1, 3'b101,3'b000,6'd20,1, 3'b100,3'b000,S_BOOT,0,16'h0));
      tbl.push_back(V("t5_blrv",   0,1,1, 3'b001,3'b000,6'd21,1, 3'b000,3'b100,S_BOOT,1,16'hD014));
      tbl.push_back(V("t5_boot0",  0,1,0, 3'b000,3'b000,6'd0,0,  3'b000,3'b000,S_BOOT,0,16'h0));
      tbl.push_back(V("t5_cpurd",  0,1,1, 3'b110,3'b000,6'd42,0, 3'b010,3'b000,S_LD,0,16'h0));
      tbl.push_back(V("t5_blnext", 0,1,1, 3'b110,3'b000,6'd42,0, 3'b100,3'b010,S_BOOT,1,16'hD015));
      tbl.push_back(V("t5_blrv2",  0,1,1, 3'b000,3'b000,6'd0,0,  3'b000,3'b100,S_BOOT,1,16'h102A));
      tbl.push_back(V("t5_rdrst",  0,1,1, 3'b100,3'b000,6'd1,0,  3'b100,3'b000,S_BOOT,0,16'h0));
      tbl.push_back(V("t5_rst",    1,1,1, 3'b100,3'b000,6'd1,0,  3'b000,3'b100,S_BOOT,1,16'h1001));
      tbl.push_back(V("t5_after",  0,1,1, 3'b000,3'b000,6'd0,0,  3'b000,3'b000,S_BOOT,0,16'h0));

      foreach (tbl[i]) apply_vec(tbl[i]);

      // Long dbg lock: unbounded by default, aborted after LM cycles with the watchdog.
      apply_vec(V("t6_boot0", 0,1,0, 3'b000,3'b000,6'd0,0, 3'b000,3'b000,S_BOOT,0,16'h0));
      apply_vec(V("t6_cpu",   0,1,0, 3'b011,3'b000,6'd0,1, 3'b010,3'b000,S_LD,0,16'h0));
      apply_vec(V("t6_lock",  0,1,0, 3'b011,3'b000,6'd0,1, 3'b001,3'b010,S_LC,0,16'h0));
      for (int k = 0; k < 20; k++) begin
`ifdef RAM_ARB_WDOG_EN
         if (k < LM)
            v = V("t6_held", 0,1,0, 3'b011,3'b000,6'd0,1, 3'b001,3'b001,S_LK,0,16'h0);
         else if ((k % 2) == 0)
            v = V("t6_rr_cpu", 0,1,0, 3'b011,3'b000,6'd0,1, 3'b010,3'b001,S_LD,0,16'h0);
         else
            v = V("t6_rr_dbg", 0,1,0, 3'b011,3'b000,6'd0,1, 3'b001,3'b010,S_LC,0,16'h0);
         v.ab = (k == LM);
`else
         v = V("t6_held", 0,1,0, 3'b011,3'b000,6'd0,1, 3'b001,3'b001,S_LK,0,16'h0);
`endif
         apply_vec(v);
      end
`ifdef RAM_ARB_WDOG_EN
      apply_vec(V("t6_rel", 0,1,0, 3'b000,3'b000,6'd0,0, 3'b000,3'b001,S_LD,0,16'h0));
`else
      apply_vec(V("t6_rel", 0,1,0, 3'b000,3'b000,6'd0,0, 3'b000,3'b001,S_LK,0,16'h0));
`endif
      apply_vec(V("t6_end", 0,1,0, 3'b000,3'b000,6'd0,0, 3'b000,3'b000,S_LD,0,16'h0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
